// File: rtl/wsm_pkg.sv
// Shared types and layer numbering for the weight streaming memory.
// The controller and the bench use the same layer IDs from here.
package wsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } wsm_state_e;

    localparam int WSM_ADDR_W = 18;

    // Descriptor layout at the default memory size.
    typedef struct packed {
        logic [WSM_ADDR_W-1:0] base;
        logic [WSM_ADDR_W:0]   len;
    } wsm_desc_t;

    localparam int WSM_MNIST_FIRST = 0;
    localparam int WSM_MNIST_LAST  = 7;
    localparam int WSM_CIFAR_FIRST = 16;
    localparam int WSM_CIFAR_LAST  = 59;

endpackage

// File: rtl/rom_generic.sv
// Flat parameter memory with a one-cycle registered read.
// The image is derived from the address; "params.mem" names the plain address ramp.
module rom_generic #(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 18,
    parameter string INIT_FILE  = "params.mem"
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    localparam bit RAMP_IMAGE = (INIT_FILE == "params.mem");

    logic [DATA_WIDTH-1:0] data_q;

    // Other image names fold the upper address bits in, so aliased pages differ.
    function automatic logic [DATA_WIDTH-1:0] image_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] fold;
        fold = '0;
        for (int i = DATA_WIDTH; i < ADDR_WIDTH; i++) begin
            fold[i % DATA_WIDTH] = fold[i % DATA_WIDTH] ^ a[i];
        end
        return RAMP_IMAGE ? a[DATA_WIDTH-1:0] : (a[DATA_WIDTH-1:0] ^ fold);
    endfunction

    always_ff @(posedge clk) begin
        if (en_i) begin
            data_q <= image_word(addr_i);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/wsm_fifo.sv
// Show-ahead FIFO with synchronous flush and occupancy count.
// The head reads as zero while empty so idle outputs stay clean.
module wsm_fifo #(
    parameter int  WIDTH = 9,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en_i && (count_q != CNT_W'(DEPTH)) && !flush_i;
    assign do_rd = rd_en_i && (count_q != '0) && !flush_i;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/weight_stream_mem.sv
// Streams a slice of one layer's parameters from the flat memory using a
// programmable (base, len) descriptor table, with prefetch, abort and error pulses.
module weight_stream_mem
    import wsm_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 18,
    parameter int    NUM_LAYERS = 64,
    parameter int    FIFO_DEPTH = 4,
    parameter string INIT_FILE  = "params.mem",
    localparam int   LAYER_W    = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [LAYER_W-1:0]    cfg_layer,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH:0]   cfg_len,
    output logic                  cfg_err,
    input  logic                  start,
    input  logic [LAYER_W-1:0]    layer_select,
    input  logic [ADDR_WIDTH-1:0] offset,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    localparam int EXT_W = ADDR_WIDTH + 2;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [EXT_W-1:0] MEM_WORDS = EXT_W'(1) << ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH:0]   len;
    } desc_t;

    desc_t                 desc_q [NUM_LAYERS];
    desc_t                 sel_desc;
    logic                  cfg_err_q;
    logic [EXT_W-1:0]      cfg_end;
    logic [EXT_W-1:0]      req_end;
    logic                  cfg_ok;
    logic                  start_ok;

    wsm_state_e            state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  req_v_q;
    logic                  req_last_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic                  rd_v_q;
    logic                  rd_last_q;

    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        pending;
    logic                  issue;
    logic                  pop;
    logic                  abort_act;

    assign sel_desc = desc_q[layer_select];
    assign cfg_end  = EXT_W'(cfg_base) + EXT_W'(cfg_len);
    assign cfg_ok   = (cfg_end <= MEM_WORDS);
    assign req_end  = EXT_W'(offset) + EXT_W'(count);
    assign start_ok = (count != '0) && (req_end <= EXT_W'(sel_desc.len));

    // Reads are only issued when the FIFO is guaranteed room for every word in flight.
    assign pending   = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(req_v_q) + (CNT_W+1)'(rd_v_q);
    assign issue     = (state_q == ST_FETCH) && (pending < (CNT_W+1)'(FIFO_DEPTH));
    assign pop       = m_valid && m_ready;
    assign abort_act = abort && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                desc_q[i] <= '0;
            end
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                desc_q[cfg_layer] <= {cfg_base, cfg_len};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            req_v_q     <= 1'b0;
            req_last_q  <= 1'b0;
            req_addr_q  <= '0;
            rd_v_q      <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            req_v_q   <= 1'b0;
            rd_v_q    <= req_v_q;
            rd_last_q <= req_last_q;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            rd_addr_q   <= sel_desc.base + offset;
                            remaining_q <= count;
                            state_q     <= ST_FETCH;
                            busy_q      <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        req_v_q     <= 1'b1;
                        req_addr_q  <= rd_addr_q;
                        req_last_q  <= (remaining_q == (ADDR_WIDTH+1)'(1));
                        rd_addr_q   <= rd_addr_q + ADDR_WIDTH'(1);
                        remaining_q <= remaining_q - (ADDR_WIDTH+1)'(1);
                        if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Abort wins over everything above: drop the reads in flight too.
            if (abort_act) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                req_v_q <= 1'b0;
                rd_v_q  <= 1'b0;
            end
        end
    end

    rom_generic #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_rom (
        .clk    (clk),
        .en_i   (req_v_q),
        .addr_i (req_addr_q),
        .data_o (rom_data)
    );

    wsm_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (abort_act),
        .wr_en_i   (rd_v_q),
        .wr_data_i ({rd_last_q, rom_data}),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_last  = fifo_head[DATA_WIDTH];
    assign m_data  = fifo_head[DATA_WIDTH-1:0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_weight_stream_mem.sv
// Randomised bench for weight_stream_mem: a descriptor/stream model predicts
// every beat, one compare process checks each cycle, literals pin the model.
module tb_weight_stream_mem;
    import wsm_pkg::*;

    localparam int DW = 8;
    localparam int AW = 18;
    localparam int NL = 64;
    localparam int LW = $clog2(NL);
    localparam int L_MNIST  = WSM_MNIST_FIRST;
    localparam int L_CIFAR0 = WSM_CIFAR_FIRST;
    localparam int L_CIFAR1 = WSM_CIFAR_FIRST + 36;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [LW-1:0] cfg_layer = '0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW:0]   cfg_len = '0;
    logic          cfg_err;
    logic          start = 1'b0;
    logic [LW-1:0] layer_select = '0;
    logic [AW-1:0] offset = '0;
    logic [AW:0]   count = '0;
    logic          abort = 1'b0;
    logic          busy, done, err, m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    weight_stream_mem #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_LAYERS (NL),
        .FIFO_DEPTH (4), .INIT_FILE ("params.mem")
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .cfg_we (cfg_we), .cfg_layer (cfg_layer), .cfg_base (cfg_base),
        .cfg_len (cfg_len), .cfg_err (cfg_err),
        .start (start), .layer_select (layer_select), .offset (offset),
        .count (count), .abort (abort),
        .busy (busy), .done (done), .err (err),
        .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_last (m_last)
    );

    int vectors = 0;
    int miscompares = 0;
    int unsigned base_m [NL];
    int unsigned len_m [NL];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int done_total = 0;
    logic prev_stall = 1'b0;
    logic prev_abort = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] img(input int unsigned a);
        return a[7:0];
    endfunction

    function automatic logic pick(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 3) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Per-cycle stream checker against the expected-word queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_abort = 1'b0;
        end else begin
            if (prev_abort) begin
                chk("valid_after_abort", 32'(m_valid), 32'd0);
            end else if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
                chk("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("beat_data", 32'(m_data), 32'(exp_q[0]));
                    chk("beat_last", 32'(m_last), 32'(exp_q.size() == 1));
                    void'(exp_q.pop_front());
                end
                got_q.push_back(m_data);
            end
            if (done) begin
                done_total++;
                chk("done_drained", 32'(exp_q.size()), 32'd0);
                chk("busy_low_at_done", 32'(busy), 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_abort = abort && busy;
        end
    end

    task automatic cfg_write(input int layer, input int unsigned base, input int unsigned len);
        logic bad;
        bad = (base + len) > (32'd1 << AW);
        cfg_we = 1'b1; cfg_layer = LW'(layer); cfg_base = AW'(base); cfg_len = (AW+1)'(len);
        @(posedge clk); #1 cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_err", 32'(cfg_err), 32'(bad));
        if (!bad) begin
            base_m[layer] = base;
            len_m[layer]  = len;
        end
    endtask

    task automatic run_fetch(input int layer, input int off, input int cnt, input int mode,
                             output int first_v, output int busy_len);
        logic ok;
        int   d0;
        ok = (cnt != 0) && (int'(off) + cnt <= int'(len_m[layer]));
        first_v = -1; busy_len = 0;
        got_q.delete();
        if (ok) for (int i = 0; i < cnt; i++) exp_q.push_back(img(base_m[layer] + off + i));
        d0 = done_total;
        layer_select = LW'(layer); offset = AW'(off); count = (AW+1)'(cnt);
        m_ready = pick(mode, 0); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_err", 32'(err), 32'(!ok));
        if (!ok) begin
            chk("busy_after_reject", 32'(busy), 32'd0);
            repeat (4) begin
                @(negedge clk);
                chk("no_valid_after_reject", 32'(m_valid), 32'd0);
            end
        end else begin
            for (int c = 0; c < 4000; c++) begin
                if (busy) busy_len++;
                if (m_valid && first_v < 0) first_v = c;
                if (done) break;
                @(posedge clk); #1 m_ready = pick(mode, c + 1);
                @(negedge clk);
            end
            repeat (3) @(negedge clk);
            chk("done_count", 32'(done_total - d0), 32'd1);
            chk("stream_complete", 32'(exp_q.size()), 32'd0);
            chk("beats_received", 32'(got_q.size()), 32'(cnt));
        end
        exp_q.delete();
        $display("fetch layer=%0d off=%0d cnt=%0d mode=%0d accepted=%0d beats=%0d first_valid=%0d busy=%0d",
                 layer, off, cnt, mode, ok, got_q.size(), first_v, busy_len);
    endtask

    initial begin
        int fv, bl, d0, lyr, off, cnt;
        int pool [5];
        pool = '{L_MNIST, WSM_MNIST_LAST, L_CIFAR0, L_CIFAR1, WSM_CIFAR_LAST};
        for (int i = 0; i < NL; i++) begin base_m[i] = 0; len_m[i] = 0; end

        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, err, cfg_err, m_valid, m_last, m_data}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        cfg_write(L_CIFAR0, 32'h100, 864);
        run_fetch(L_CIFAR0, 0, 8, 0, fv, bl);
        chk("first_valid_latency", 32'(fv), 32'd3);
        chk("busy_cycles", 32'(bl), 32'd11);
        if (got_q.size() == 8) begin
            chk("lit_first_word", 32'(got_q[0]), 32'h00);
            chk("lit_last_word", 32'(got_q[7]), 32'h07);
        end

        cfg_write(L_CIFAR1, 32'h400, 1000);
        run_fetch(L_CIFAR1, 996, 4, 1, fv, bl);
        if (got_q.size() == 4) begin
            chk("lit_l52_first", 32'(got_q[0]), 32'hE4);
            chk("lit_l52_last", 32'(got_q[3]), 32'hE7);
        end
        run_fetch(L_CIFAR1, 990, 20, 0, fv, bl);
        run_fetch(L_CIFAR1, 0, 0, 0, fv, bl);

        cfg_write(L_CIFAR1, 32'h3FF00, 32'h200);
        run_fetch(L_CIFAR1, 996, 4, 0, fv, bl);
        if (got_q.size() == 4) chk("lit_old_desc", 32'(got_q[0]), 32'hE4);

        // Stall then abort a long fetch, then restart on the same layer.
        cfg_write(L_MNIST, 32'h2000, 128);
        got_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(img(32'h2000 + i));
        layer_select = LW'(L_MNIST); offset = '0; count = (AW+1)'(64);
        m_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("stalled_busy", 32'(busy), 32'd1);
        chk("stalled_valid", 32'(m_valid), 32'd1);
        chk("stalled_no_beats", 32'(got_q.size()), 32'd0);
        d0 = done_total;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; exp_q.delete();
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", 32'(done_total - d0), 32'd0);
        $display("abort after 64-word stall: busy=%0d valid=%0d", busy, m_valid);
        run_fetch(L_MNIST, 0, 16, 2, fv, bl);
        if (got_q.size() == 16) chk("lit_restart_first", 32'(got_q[0]), 32'h00);

        for (int t = 0; t < 12; t++) begin
            lyr = pool[t % 5];
            if (t % 3 == 0) cfg_write(lyr, $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 400));
            off = int'($urandom_range(0, len_m[lyr] + 2));
            cnt = int'($urandom_range(0, 24));
            run_fetch(lyr, off, cnt, 2, fv, bl);
        end

        // Reset in the middle of a 32-word fetch.
        cfg_write(L_CIFAR0, 32'h100, 864);
        got_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(img(32'h100 + i));
        layer_select = LW'(L_CIFAR0); offset = '0; count = (AW+1)'(32);
        m_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 100 && got_q.size() < 5; c++) @(negedge clk);
        chk("reached_word5", 32'(got_q.size()), 32'd5);
        #2 rst_n = 1'b0;
        #1 chk("midstream_reset_outputs", 32'({busy, done, err, cfg_err, m_valid, m_last, m_data}), 32'd0);
        exp_q.delete();
        for (int i = 0; i < NL; i++) begin base_m[i] = 0; len_m[i] = 0; end
        $display("reset asserted after %0d words", got_q.size());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_fetch(L_CIFAR0, 0, 1, 0, fv, bl);
        cfg_write(L_CIFAR0, 32'h100, 864);
        run_fetch(L_CIFAR0, 3, 5, 2, fv, bl);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/weight_stream_mem.md
Name: weight_stream_mem

Overview:
- Parametrised successor to the per-layer weight/bias ROM bank.
- Replaces the 64 fixed-size ROMs and the combinational layer mux with one flat parameter memory, plus a programmable per-layer descriptor table (base, length).
- A fetch FSM streams a requested slice of a layer's parameters to the CNN datapath over a valid/ready interface, with prefetch buffering, a last-beat flag, abort and error reporting.
- Sits between the CNN accelerator controller (start/cfg) and the MAC array operand loaders (stream).

Parameters:
- DATA_WIDTH, 8, width of one parameter word.
- ADDR_WIDTH, 18, flat memory address width; depth is 2**ADDR_WIDTH words.
- NUM_LAYERS, 64, number of descriptor entries. LAYER_W = $clog2(NUM_LAYERS).
- FIFO_DEPTH, 4, output prefetch FIFO entries; must be a power of 2 and >= 4.
- INIT_FILE, "params.mem", hex image loaded into the flat memory.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  descriptor write strobe
- cfg_layer  in  LAYER_W  descriptor index to write
- cfg_base  in  ADDR_WIDTH  layer base address
- cfg_len  in  ADDR_WIDTH+1  layer length in words
- cfg_err  out  1  one-cycle pulse when a descriptor write is rejected
- start  in  1  fetch request, sampled only when busy=0
- layer_select  in  LAYER_W  layer to fetch
- offset  in  ADDR_WIDTH  first word within the layer
- count  in  ADDR_WIDTH+1  number of words to stream
- abort  in  1  synchronous flush of the current fetch
- busy  out  1  high from start acceptance until done/err/abort
- done  out  1  one-cycle pulse after the last beat handshake
- err  out  1  one-cycle pulse when a start request is rejected
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  parameter word
- m_last  out  1  marks the final word of the fetch

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0; FSM IDLE; FIFO empty; descriptors base=0, len=0.
- Mid-operation reset: the fetch is discarded, nothing is resumed, descriptors are cleared.
- Descriptor writes:
  - On cfg_we, the entry is written at the clock edge.
  - The write is rejected (entry unchanged, cfg_err pulses next cycle) if cfg_base + cfg_len > 2**ADDR_WIDTH, computed at ADDR_WIDTH+2 bits.
  - Writes are allowed while busy. A running fetch uses the base/len it latched at start.
- Start check, only when busy=0:
  - start with count==0, or offset+count > len[layer_select] → err pulse next cycle, busy stays 0.
  - Otherwise latch rd_addr = base+offset, remaining = count; go to FETCH; busy=1 next cycle.
  - start while busy=1 is ignored with no err.
- FSM states: IDLE → FETCH → DRAIN → IDLE.
  - FETCH: issue one read per cycle while (in-flight reads + FIFO occupancy) < FIFO_DEPTH. On each issue, rd_addr++ and remaining--. The last issued read is tagged last. Move to DRAIN after the final read is issued.
  - DRAIN: wait until the last-tagged word's handshake completes, pulse done, then go to IDLE. busy drops in the same cycle done is high.
- Memory read latency is 1 cycle (registered read). Its output is written into the FIFO with its tag; the FIFO is show-ahead.
- Timing:
  - With m_ready held high, first m_valid is exactly 3 cycles after the start-accepting edge.
  - Throughput is then 1 word/cycle.
  - Total busy length for N words is N+3 cycles.
- Stream rules:
  - m_data and m_last are held stable while m_valid & !m_ready.
  - m_valid never depends combinationally on m_ready.
  - m_last=1 only on the final word.
- abort has priority over every other input in the same cycle:
  - FIFO flushed and in-flight read discarded.
  - m_valid=0 next cycle; FSM to IDLE; busy=0 next cycle; no done.
  - abort while IDLE has no effect.
- Simultaneous last handshake and a new start: the start is ignored because busy is still 1 that cycle.
- Arithmetic: unsigned throughout. Address increments never wrap, because the start and cfg checks guarantee bounds.

Decomposition:
- Package wsm_pkg:
  - fsm state enum (IDLE, FETCH, DRAIN);
  - descriptor struct {base, len};
  - the localparam layer IDs for MNIST (0–7) and CIFAR (16–59), so the controller and the bench share them.
- One sub-module: wsm_fifo, a parametrised show-ahead FIFO of {last, data} with flush and occupancy count.
- The flat memory reuses the existing rom_generic.

Test Plan:
- Program layer 16 base=0x100, len=864 from an image where mem[a]=a[7:0]; start offset=0 count=8 with m_ready=1 → m_valid at cycle 3, data 0x00..0x07, m_last on 0x07, done one cycle after, busy 11 cycles.
- Layer 52 base=0x400 len=1000, start offset=996 count=4, m_ready toggling 1,0,0,1… → data 0xE4..0xE7 (base 0x400 contributes nothing to the low byte; 996 = 0x3E4), stable during stalls, no loss or duplication, single done.
- Start offset=990 count=20 on the same layer → err pulse, busy stays 0, m_valid never asserts. Separately, count=0 → err.
- Descriptor write base=0x3FF00 len=0x200 → cfg_err pulse, entry unchanged (old fetch still returns the old data).
- Start count=64, m_ready=0 for 10 cycles, then abort → occupancy capped at 4, m_valid drops the next cycle, no done. A following start on layer 0 streams correctly from its first word.
- Assert rst_n low mid-stream at word 5 of 32 → all outputs 0 immediately; after release, descriptors read len=0 and start gives err.
